// File: rtl/shifter_serial_io_pkg.sv
// Shared types and constants for the serial front/back end of the shifter.
package shifter_serial_io_pkg;

    localparam int unsigned DefaultWidth = 8;

    // Job sequencing: collect operands, let the shifter settle, stream the result.
    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StLoad = 2'd1,
        StExec = 2'd2,
        StSend = 2'd3
    } state_e;

    // Bit counter must hold 2*width without wrapping.
    function automatic int unsigned cnt_width(input int unsigned width);
        return $clog2(2 * width) + 1;
    endfunction

endpackage

// File: rtl/shifter_serial_io_if.sv
// Serial link plus shifter operand/result bundle.
interface shifter_serial_io_if
    import shifter_serial_io_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) ();

    logic             sin;
    logic             in_valid;
    logic             in_rdy;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] n;
    logic [WIDTH-1:0] w;
    logic             sout;
    logic             sout_valid;
    logic             busy;
    logic             done;

    // Environment side: drives the serial stream and the shifter result.
    modport master (
        output sin, in_valid, w,
        input  in_rdy, d, n, sout, sout_valid, busy, done
    );

    // Serial front/back end side.
    modport slave (
        input  sin, in_valid, w,
        output in_rdy, d, n, sout, sout_valid, busy, done
    );

endinterface

// File: rtl/shifter_serial_io_serial_shift_reg.sv
// MSB-first shift register with parallel load; serial out is the current MSB.
module shifter_serial_io_serial_shift_reg
    import shifter_serial_io_pkg::*;
#(
    parameter int unsigned WIDTH = DefaultWidth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift,
    input  logic             sin,
    input  logic [WIDTH-1:0] pdata,
    output logic [WIDTH-1:0] q,
    output logic             sout
);

    logic [WIDTH-1:0] data_q;

    // Parallel load wins over shift; new bits enter at the LSB.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
        end else if (load) begin
            data_q <= pdata;
        end else if (shift) begin
            data_q <= {data_q[WIDTH-2:0], sin};
        end
    end

    assign q    = data_q;
    assign sout = data_q[WIDTH-1];

endmodule

// File: rtl/shifter_serial_io.sv
// Serial operand assembly, settle wait, result capture and serial result streaming.
module shifter_serial_io
    import shifter_serial_io_pkg::*;
#(
    parameter int unsigned WIDTH  = DefaultWidth,
    parameter int unsigned SETTLE = 1
) (
    input logic                clk,
    input logic                rst,
    shifter_serial_io_if.slave bus
);

    localparam int unsigned     CntW     = cnt_width(WIDTH);
    localparam int unsigned     SetW     = (SETTLE > 1) ? $clog2(SETTLE) : 1;
    localparam logic [CntW-1:0] LoadLast = CntW'(2 * WIDTH - 1);
    localparam logic [CntW-1:0] SendLast = CntW'(WIDTH - 1);
    localparam logic [SetW-1:0] SetLast  = SetW'(SETTLE - 1);

    state_e             state_q, state_d;
    logic [CntW-1:0]    cnt_q, cnt_d;
    logic [SetW-1:0]    set_q, set_d;
    logic [WIDTH-1:0]   d_q, n_q;
    logic [2*WIDTH-1:0] in_q;
    logic [2*WIDTH-1:0] in_next;
    logic               accept;
    logic               load_last;
    logic               capture;
    logic               send_last;
    logic               res_sout;
    logic [WIDTH-1:0]   res_q_unused;
    logic               in_sout_unused;
    logic               in_msb_unused;

    assign accept    = bus.in_valid && (state_q == StIdle || state_q == StLoad);
    assign load_last = accept && (state_q == StLoad) && (cnt_q == LoadLast);
    assign capture   = (state_q == StExec) && (set_q == SetLast);
    assign send_last = (state_q == StSend) && (cnt_q == SendLast);

    // Operand word as it will stand after the final accepted bit shifts in.
    assign in_next       = {in_q[2*WIDTH-2:0], bus.sin};
    assign in_msb_unused = in_q[2*WIDTH-1];

    shifter_serial_io_serial_shift_reg #(
        .WIDTH (2 * WIDTH)
    ) u_in_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (1'b0),
        .shift (accept),
        .sin   (bus.sin),
        .pdata ('0),
        .q     (in_q),
        .sout  (in_sout_unused)
    );

    shifter_serial_io_serial_shift_reg #(
        .WIDTH (WIDTH)
    ) u_res_sr (
        .clk   (clk),
        .rst   (rst),
        .load  (capture),
        .shift (state_q == StSend),
        .sin   (1'b0),
        .pdata (bus.w),
        .q     (res_q_unused),
        .sout  (res_sout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept)    state_d = StLoad;
            StLoad:  if (load_last) state_d = StExec;
            StExec:  if (capture)   state_d = StSend;
            StSend:  if (send_last) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Bit counter (load and send phases) and settle counter next values.
    always_comb begin
        cnt_d = cnt_q;
        set_d = set_q;
        unique case (state_q)
            StIdle: if (accept) cnt_d = CntW'(1);
            StLoad: begin
                if (load_last) begin
                    cnt_d = '0;
                end else if (accept) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StExec:  set_d = capture ? '0 : set_q + 1'b1;
            StSend:  cnt_d = send_last ? '0 : cnt_q + 1'b1;
            default: ;
        endcase
    end

    // Counters and operand registers; d/n change only on the final load edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            set_q <= '0;
            d_q   <= '0;
            n_q   <= '0;
        end else begin
            cnt_q <= cnt_d;
            set_q <= set_d;
            if (load_last) begin
                d_q <= in_next[2*WIDTH-1:WIDTH];
                n_q <= in_next[WIDTH-1:0];
            end
        end
    end

    // Output decode from current state.
    always_comb begin
        bus.in_rdy     = 1'b0;
        bus.busy       = 1'b1;
        bus.sout_valid = 1'b0;
        bus.sout       = 1'b0;
        bus.done       = 1'b0;
        unique case (state_q)
            StIdle: begin
                bus.in_rdy = 1'b1;
                bus.busy   = 1'b0;
            end
            StLoad: bus.in_rdy = 1'b1;
            StExec: ;
            StSend: begin
                bus.sout_valid = 1'b1;
                bus.sout       = res_sout;
                bus.done       = (cnt_q == SendLast);
            end
            default: ;
        endcase
    end

    assign bus.d = d_q;
    assign bus.n = n_q;

endmodule

// File: tb/tb_shifter_serial_io.sv
// Directed bench: two instances (SETTLE=1 and SETTLE=3) with stub shifter w = d ^ n.
module tb_shifter_serial_io;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic sin = 1'b0;
    logic in_valid = 1'b0;
    logic sel = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_d = 8'h00;
    logic [7:0] exp_n = 8'h00;

    always #5 clk = ~clk;

    shifter_serial_io_if #(.WIDTH(8)) bus1 ();
    shifter_serial_io_if #(.WIDTH(8)) bus3 ();

    assign bus1.sin      = sin;
    assign bus1.in_valid = in_valid;
    assign bus1.w        = bus1.d ^ bus1.n;
    assign bus3.sin      = sin;
    assign bus3.in_valid = in_valid;
    assign bus3.w        = bus3.d ^ bus3.n;

    shifter_serial_io #(.WIDTH(8), .SETTLE(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1)
    );

    shifter_serial_io #(.WIDTH(8), .SETTLE(3)) dut3 (
        .clk (clk),
        .rst (rst),
        .bus (bus3)
    );

    logic       o_in_rdy, o_sout, o_sout_valid, o_busy, o_done;
    logic [7:0] o_d, o_n;

    assign o_in_rdy     = sel ? bus3.in_rdy     : bus1.in_rdy;
    assign o_sout       = sel ? bus3.sout       : bus1.sout;
    assign o_sout_valid = sel ? bus3.sout_valid : bus1.sout_valid;
    assign o_busy       = sel ? bus3.busy       : bus1.busy;
    assign o_done       = sel ? bus3.done       : bus1.done;
    assign o_d          = sel ? bus3.d          : bus1.d;
    assign o_n          = sel ? bus3.n          : bus1.n;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset(input string tag);
        rst      = 1'b1;
        in_valid = 1'b0;
        sin      = 1'b0;
        step();
        chk({tag, " rst in_rdy"}, o_in_rdy, 1);
        chk({tag, " rst busy"}, o_busy, 0);
        chk({tag, " rst done"}, o_done, 0);
        chk({tag, " rst sout_valid"}, o_sout_valid, 0);
        chk({tag, " rst sout"}, o_sout, 0);
        chk({tag, " rst d"}, o_d, 0);
        chk({tag, " rst n"}, o_n, 0);
        step();
        rst   = 1'b0;
        exp_d = 8'h00;
        exp_n = 8'h00;
    endtask

    // Sends the top nbits of v MSB first, optionally with random idle gaps.
    task automatic send_bits(input logic [15:0] v, input int nbits, input bit gaps,
                             input string tag);
        int g;
        for (int k = 0; k < nbits; k++) begin
            g = gaps ? int'($urandom_range(0, 2)) : 0;
            for (int j = 0; j < g; j++) begin
                in_valid = 1'b0;
                sin      = 1'b1;
                step();
                chk({tag, " gap in_rdy"}, o_in_rdy, 1);
                chk({tag, " gap d"}, o_d, exp_d);
            end
            sin      = v[15-k];
            in_valid = 1'b1;
            step();
            in_valid = 1'b0;
            if (k == 15) begin
                chk({tag, " loaded d"}, o_d, v[15:8]);
                chk({tag, " loaded n"}, o_n, v[7:0]);
                chk({tag, " exec in_rdy"}, o_in_rdy, 0);
                chk({tag, " exec busy"}, o_busy, 1);
                exp_d = v[15:8];
                exp_n = v[7:0];
            end else begin
                chk({tag, " load d held"}, o_d, exp_d);
                chk({tag, " load n held"}, o_n, exp_n);
                chk({tag, " load busy"}, o_busy, 1);
                chk({tag, " load sout_valid"}, o_sout_valid, 0);
            end
        end
    endtask

    // Entered one step after the last load edge; follows the job back to IDLE.
    task automatic run_out(input int settle, input logic [7:0] exp, input bit hold,
                           input string tag);
        logic [7:0] got;
        int bits, cyc, first, done_at, done_cnt;
        got      = 8'h00;
        bits     = 0;
        cyc      = 0;
        first    = -1;
        done_at  = -1;
        done_cnt = 0;
        while (o_busy && cyc < 40) begin
            chk({tag, " busy in_rdy"}, o_in_rdy, 0);
            if (o_sout_valid) begin
                if (first < 0) first = cyc;
                got = {got[6:0], o_sout};
                if (o_done) begin
                    done_at = bits;
                    done_cnt++;
                end
                bits++;
            end else if (o_done) begin
                done_cnt++;
            end
            sin      = 1'b1;
            in_valid = hold && !o_done;
            step();
            cyc++;
        end
        in_valid = 1'b0;
        chk({tag, " result"}, got, exp);
        chk({tag, " bit count"}, bits, 8);
        chk({tag, " first sout cycle"}, first, settle);
        chk({tag, " done position"}, done_at, 7);
        chk({tag, " done pulses"}, done_cnt, 1);
        chk({tag, " busy cycles"}, cyc, settle + 8);
        chk({tag, " idle in_rdy"}, o_in_rdy, 1);
    endtask

    initial begin
        // 1: contiguous load, FF ^ 80 = 7F
        sel = 1'b0;
        do_reset("t1");
        send_bits(16'hFF80, 16, 1'b0, "t1");
        run_out(1, 8'h7F, 1'b0, "t1");

        // 2: gapped load, 58 ^ 20 = 78; d/n hold FF/80 until the last bit
        send_bits(16'h5820, 16, 1'b1, "t2");
        run_out(1, 8'h78, 1'b0, "t2");

        // 3: in_valid held through EXEC/SEND is dropped; next job unaffected
        send_bits(16'h3C0F, 16, 1'b0, "t3a");
        run_out(1, 8'h33, 1'b1, "t3a");
        step();
        step();
        chk("t3 no stray job", o_busy, 0);
        send_bits(16'hC381, 16, 1'b0, "t3b");
        run_out(1, 8'h42, 1'b0, "t3b");

        // 4: abort after 10 bits, then a zero job
        send_bits(16'hAA55, 10, 1'b0, "t4a");
        do_reset("t4");
        send_bits(16'h0000, 16, 1'b0, "t4b");
        run_out(1, 8'h00, 1'b0, "t4b");

        // 5: SETTLE=3 instance, 01 ^ 10 = 11
        sel = 1'b1;
        do_reset("t5");
        send_bits(16'h0110, 16, 1'b0, "t5");
        run_out(3, 8'h11, 1'b0, "t5");

        // 6: back-to-back jobs, job 2 starts in the first IDLE cycle
        sel = 1'b0;
        do_reset("t6");
        send_bits(16'hF00C, 16, 1'b0, "t6a");
        run_out(1, 8'hFC, 1'b0, "t6a");
        send_bits(16'h1234, 16, 1'b0, "t6b");
        run_out(1, 8'h26, 1'b0, "t6b");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
